mem_stage_unit: RTL and testbench

- MEM-stage consumer of the packed 500-bit EX/MEM pipeline bus.
- Decodes the bus fields and resolves branches (PCSrc).
- Runs loads/stores against data memory over a req/ready handshake, stalling upstream stages while an access is outstanding.
- Registers the result into the packed MEM/WB bus that feeds write-back.

---
 rtl/mem_stage_unit.sv | 161 ++++++++++++++++
 tb/tb_mem_stage_unit.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/mem_stage_unit.sv
// MEM stage: decodes the EX/MEM bus, resolves branches, runs data-memory accesses over
// a req/ready handshake and registers the MEM/WB bus. Optional macro: MEM_ALIGN_CHECK_EN.
module mem_stage_unit #(
    parameter int BUS_W  = 500,
    parameter int DATA_W = 64,
    parameter int CNT_W  = 32
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [BUS_W-1:0]  PR3,
    output logic [BUS_W-1:0]  PR4,
    output logic              stall,
    output logic              pcsrc,
    output logic [DATA_W-1:0] branch_target,
    output logic              dmem_req,
    output logic              dmem_we,
    output logic [DATA_W-1:0] dmem_addr,
    output logic [DATA_W-1:0] dmem_wdata,
    input  logic [DATA_W-1:0] dmem_rdata,
    input  logic              dmem_ready,
    output logic [CNT_W-1:0]  stall_cycles,
    output logic              align_fault
);

    typedef enum logic [1:0] {IDLE, ACCESS, COMPLETE} state_t;

    state_t             state_q, state_d;
    logic [BUS_W-1:0]   pr4_q, pr4_d;
    logic [DATA_W-1:0]  rdata_q, rdata_d;
    logic [CNT_W-1:0]   stall_cycles_q, stall_cycles_d;
    logic               fault_q, fault_d;
    logic               align_fault_q, align_fault_d;
    logic               stall_c, req_c;

    logic [4:0]         rt;
    logic               branch, mem_read, mem_write, mem_to_reg, reg_write, zero;
    logic [DATA_W-1:0]  alu_result;
    logic               is_load, memop, misaligned;

    assign rt         = PR3[4:0];
    assign branch     = PR3[99];
    assign mem_read   = PR3[100];
    assign mem_write  = PR3[101];
    assign mem_to_reg = PR3[102];
    assign reg_write  = PR3[103];
    assign zero       = PR3[360];
    assign alu_result = PR3[424:361];

    // A store wins when both MemRead and MemWrite are set.
    assign is_load = mem_read & ~mem_write;
    assign memop   = mem_read | mem_write;

`ifdef MEM_ALIGN_CHECK_EN
    assign misaligned  = |alu_result[2:0];
    assign align_fault = align_fault_q;
`else
    assign misaligned  = 1'b0;
    assign align_fault = 1'b0;
`endif

    assign branch_target = PR3[359:296];
    assign dmem_we       = mem_write;
    assign dmem_addr     = alu_result;
    assign dmem_wdata    = PR3[231:168];

    assign stall        = stall_c & ~reset;
    assign dmem_req     = req_c & ~reset;
    assign pcsrc        = branch & zero & ~stall;
    assign PR4          = pr4_q;
    assign stall_cycles = stall_cycles_q;

    function automatic logic [BUS_W-1:0] pack_wb(
        input logic [4:0]        f_rt,
        input logic [DATA_W-1:0] f_ld,
        input logic [DATA_W-1:0] f_alu,
        input logic              f_m2r,
        input logic              f_rw,
        input logic              f_done
    );
        pack_wb          = '0;
        pack_wb[4:0]     = f_rt;
        pack_wb[68:5]    = f_ld;
        pack_wb[132:69]  = f_alu;
        pack_wb[133]     = f_m2r;
        pack_wb[134]     = f_rw;
        pack_wb[135]     = f_done;
    endfunction

    always_comb begin
        state_d       = state_q;
        pr4_d         = pr4_q;
        rdata_d       = rdata_q;
        fault_d       = fault_q;
        align_fault_d = align_fault_q;
        stall_c       = 1'b0;
        req_c         = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (memop) begin
                    stall_c = 1'b1;
                    pr4_d   = '0;
                    if (misaligned) begin
                        state_d       = COMPLETE;
                        fault_d       = 1'b1;
                        align_fault_d = 1'b1;
                    end else begin
                        state_d = ACCESS;
                    end
                end else begin
                    pr4_d = pack_wb(rt, '0, alu_result, mem_to_reg, reg_write, 1'b0);
                end
            end
            ACCESS: begin
                stall_c = 1'b1;
                req_c   = 1'b1;
                pr4_d   = '0;
                if (dmem_ready) begin
                    if (is_load) rdata_d = dmem_rdata;
                    state_d = COMPLETE;
                end
            end
            COMPLETE: begin
                // Faulted accesses never reached memory, so neither data nor write-back survive.
                pr4_d   = pack_wb(rt, (is_load && !fault_q) ? rdata_q : '0, alu_result,
                                  mem_to_reg, reg_write & ~fault_q, 1'b1);
                fault_d = 1'b0;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        stall_cycles_d = (stall_c && !(&stall_cycles_q)) ? stall_cycles_q + CNT_W'(1)
                                                         : stall_cycles_q;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q        <= IDLE;
            pr4_q          <= '0;
            rdata_q        <= '0;
            stall_cycles_q <= '0;
            fault_q        <= 1'b0;
            align_fault_q  <= 1'b0;
        end else begin
            state_q        <= state_d;
            pr4_q          <= pr4_d;
            rdata_q        <= rdata_d;
            stall_cycles_q <= stall_cycles_d;
            fault_q        <= fault_d;
            align_fault_q  <= align_fault_d;
        end
    end

    logic unused_ok;
`ifdef MEM_ALIGN_CHECK_EN
    assign unused_ok = ^{PR3[98:5], PR3[167:104], PR3[295:232], PR3[BUS_W-1:425]};
`else
    assign unused_ok = ^{PR3[98:5], PR3[167:104], PR3[295:232], PR3[BUS_W-1:425],
                         align_fault_q};
`endif

endmodule

// File: tb/tb_mem_stage_unit.sv
// Directed bench for mem_stage_unit: vector table for pass-through/branch decode plus
// hand-written memory access, reset-abort and alignment sequences.
module tb_mem_stage_unit;

    logic         clock;
    logic         reset;
    logic [499:0] PR3;
    logic [499:0] PR4;
    logic         stall, pcsrc, dmem_req, dmem_we, dmem_ready, align_fault;
    logic [63:0]  branch_target, dmem_addr, dmem_wdata, dmem_rdata;
    logic [31:0]  stall_cycles;

    int tests = 0;
    int fails = 0;

    mem_stage_unit #(.BUS_W(500), .DATA_W(64), .CNT_W(32)) dut (
        .clock(clock), .reset(reset), .PR3(PR3), .PR4(PR4), .stall(stall), .pcsrc(pcsrc),
        .branch_target(branch_target), .dmem_req(dmem_req), .dmem_we(dmem_we),
        .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata), .dmem_rdata(dmem_rdata),
        .dmem_ready(dmem_ready), .stall_cycles(stall_cycles), .align_fault(align_fault)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string name, input logic [511:0] act, input logic [511:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [499:0] mk_pr3(input logic [4:0] rt, input logic br,
            input logic mr, input logic mw, input logic m2r, input logic rw,
            input logic [63:0] wdata, input logic [63:0] target, input logic zero,
            input logic [63:0] alu);
        logic [499:0] v;
        v = '0;
        v[4:0] = rt; v[99] = br; v[100] = mr; v[101] = mw; v[102] = m2r; v[103] = rw;
        v[231:168] = wdata; v[359:296] = target; v[360] = zero; v[424:361] = alu;
        return v;
    endfunction

    function automatic logic [499:0] exp_pr4(input logic [4:0] rt, input logic [63:0] ld,
            input logic [63:0] alu, input logic m2r, input logic rw, input logic done);
        logic [499:0] v;
        v = '0;
        v[4:0] = rt; v[68:5] = ld; v[132:69] = alu; v[133] = m2r; v[134] = rw; v[135] = done;
        return v;
    endfunction

    // Drives one memory instruction until its COMPLETE cycle, answering the
    // (wait_n+1)-th request cycle with a ready pulse. Leaves PR3 as a NOP.
    task automatic do_access(input logic [499:0] v, input int wait_n, input logic [63:0] rd,
            output int stalls, output int reqs, output logic we, output logic [63:0] addr,
            output logic [63:0] wdata, output logic bubble_bad);
        int  n;
        bit  done, prev;
        @(negedge clock);
        PR3 = v; dmem_ready = 1'b0;
        stalls = 0; reqs = 0; n = 0; done = 0; prev = 0; bubble_bad = 0;
        we = 1'b0; addr = '0; wdata = '0;
        while (!done && n < 40) begin
            #1;
            if (prev && PR4 !== '0) bubble_bad = 1'b1;
            if (stall) stalls++;
            if (dmem_req) begin
                reqs++;
                we = dmem_we; addr = dmem_addr; wdata = dmem_wdata;
                if (reqs == wait_n + 1) begin
                    dmem_ready = 1'b1; dmem_rdata = rd;
                end
            end
            if (!stall && n > 0) done = 1;
            prev = stall;
            n++;
            @(negedge clock);
            dmem_ready = 1'b0;
        end
        PR3 = '0;
        tests++;
        if (!done) begin
            fails++;
            $display("FAIL access_timeout: got %0d cycles required completion", n);
        end
    endtask

    typedef struct {
        logic [4:0]  rt;
        logic        rw, m2r, br, zero;
        logic [63:0] alu, target;
        logic        exp_pcsrc;
    } vec_t;

    vec_t vecs [5];

    int          st, rq;
    logic        we, bb;
    logic [63:0] ad, wd;

    initial begin
        vecs[0] = '{rt: 5'd5,  rw: 1, m2r: 0, br: 0, zero: 0, alu: 64'h1234,
                    target: 64'h0,   exp_pcsrc: 0};
        vecs[1] = '{rt: 5'd2,  rw: 0, m2r: 0, br: 1, zero: 1, alu: 64'h0,
                    target: 64'h200, exp_pcsrc: 1};
        vecs[2] = '{rt: 5'd3,  rw: 0, m2r: 0, br: 1, zero: 0, alu: 64'h8,
                    target: 64'h200, exp_pcsrc: 0};
        vecs[3] = '{rt: 5'd4,  rw: 1, m2r: 0, br: 0, zero: 1, alu: 64'h0,
                    target: 64'h300, exp_pcsrc: 0};
        vecs[4] = '{rt: 5'd31, rw: 0, m2r: 1, br: 0, zero: 0, alu: 64'hFFFF_FFFF_FFFF_FFFF,
                    target: 64'hABC, exp_pcsrc: 0};

        reset = 1'b1; PR3 = '0; dmem_ready = 1'b0; dmem_rdata = '0;
        repeat (2) @(posedge clock);
        #1;
        chk("rst_pr4", PR4, '0);
        chk("rst_stall", stall, 0);
        chk("rst_req", dmem_req, 0);
        chk("rst_cnt", stall_cycles, 0);
        chk("rst_align", align_fault, 0);
        @(negedge clock);
        reset = 1'b0;

        for (int i = 0; i < 5; i++) begin
            @(negedge clock);
            PR3 = mk_pr3(vecs[i].rt, vecs[i].br, 0, 0, vecs[i].m2r, vecs[i].rw, 64'h0,
                         vecs[i].target, vecs[i].zero, vecs[i].alu);
            #1;
            chk($sformatf("vec%0d_pcsrc", i), pcsrc, vecs[i].exp_pcsrc);
            chk($sformatf("vec%0d_target", i), branch_target, vecs[i].target);
            chk($sformatf("vec%0d_stall", i), stall, 0);
            @(posedge clock);
            #1;
            chk($sformatf("vec%0d_pr4", i), PR4,
                exp_pr4(vecs[i].rt, 64'h0, vecs[i].alu, vecs[i].m2r, vecs[i].rw, 0));
        end

        // Load to 0x40, two wait cycles.
        do_access(mk_pr3(5'd7, 0, 1, 0, 1, 1, 64'h0, 64'h0, 0, 64'h40), 2, 64'hDEADBEEF,
                  st, rq, we, ad, wd, bb);
        #1;
        chk("ld_stalls", st, 4);
        chk("ld_reqs", rq, 3);
        chk("ld_we", we, 0);
        chk("ld_addr", ad, 64'h40);
        chk("ld_bubble", bb, 0);
        chk("ld_pr4", PR4, exp_pr4(5'd7, 64'hDEADBEEF, 64'h40, 1, 1, 1));
        chk("ld_cnt", stall_cycles, 4);

        // Store of 0xAA55 to 0x80, ready on first ACCESS cycle.
        do_access(mk_pr3(5'd3, 0, 0, 1, 0, 0, 64'hAA55, 64'h0, 0, 64'h80), 0, 64'h5555,
                  st, rq, we, ad, wd, bb);
        #1;
        chk("st_stalls", st, 2);
        chk("st_reqs", rq, 1);
        chk("st_we", we, 1);
        chk("st_addr", ad, 64'h80);
        chk("st_wdata", wd, 64'hAA55);
        chk("st_pr4", PR4, exp_pr4(5'd3, 64'h0, 64'h80, 0, 0, 1));
        chk("st_cnt", stall_cycles, 6);

        // MemRead and MemWrite both set: store wins, no load data.
        do_access(mk_pr3(5'd9, 0, 1, 1, 1, 1, 64'h77, 64'h0, 0, 64'h100), 1, 64'h1111,
                  st, rq, we, ad, wd, bb);
        #1;
        chk("both_we", we, 1);
        chk("both_stalls", st, 3);
        chk("both_pr4", PR4, exp_pr4(5'd9, 64'h0, 64'h100, 1, 1, 1));

        // Reset while in ACCESS, late ready afterwards.
        @(negedge clock);
        PR3 = mk_pr3(5'd4, 0, 1, 0, 1, 1, 64'h0, 64'h0, 0, 64'h40);
        @(posedge clock);
        @(negedge clock);
        #1;
        chk("ra_req_before", dmem_req, 1);
        reset = 1'b1;
        #1;
        chk("ra_req_drop", dmem_req, 0);
        chk("ra_stall_drop", stall, 0);
        @(posedge clock);
        @(negedge clock);
        reset = 1'b0; PR3 = '0; dmem_ready = 1'b1; dmem_rdata = 64'hBAD;
        #1;
        chk("ra_pr4", PR4, '0);
        chk("ra_cnt", stall_cycles, 0);
        @(posedge clock);
        @(negedge clock);
        dmem_ready = 1'b0;
        #1;
        chk("ra_late_req", dmem_req, 0);
        chk("ra_late_pr4", PR4, '0);
        chk("ra_late_stall", stall, 0);
        PR3 = mk_pr3(5'd5, 0, 0, 0, 0, 1, 64'h0, 64'h0, 0, 64'h1234);
        @(posedge clock);
        #1;
        chk("ra_idle_pass", PR4, exp_pr4(5'd5, 64'h0, 64'h1234, 0, 1, 0));

`ifdef MEM_ALIGN_CHECK_EN
        do_access(mk_pr3(5'd6, 0, 1, 0, 1, 1, 64'h0, 64'h0, 0, 64'h43), 0, 64'h99,
                  st, rq, we, ad, wd, bb);
        #1;
        chk("al_reqs", rq, 0);
        chk("al_stalls", st, 1);
        chk("al_fault", align_fault, 1);
        chk("al_pr4", PR4, exp_pr4(5'd6, 64'h0, 64'h43, 1, 0, 1));
        repeat (3) @(posedge clock);
        #1;
        chk("al_fault_held", align_fault, 1);
`else
        do_access(mk_pr3(5'd6, 0, 1, 0, 1, 1, 64'h0, 64'h0, 0, 64'h43), 0, 64'h99,
                  st, rq, we, ad, wd, bb);
        #1;
        chk("na_reqs", rq, 1);
        chk("na_addr", ad, 64'h43);
        chk("na_fault", align_fault, 0);
        chk("na_pr4", PR4, exp_pr4(5'd6, 64'h99, 64'h43, 1, 1, 1));
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
